// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bundle for the scoreboarded register file
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);
    logic [NREAD*AW-1:0]   rs;
    logic [NREAD-1:0]      rs_used;
    logic [NREAD*XLEN-1:0] RUrs;
    logic [NREAD-1:0]      rs_busy;
    logic                  hazard;
    logic                  RUWr;
    logic [AW-1:0]         rd;
    logic [XLEN-1:0]       Datawr;
    logic                  iss_en;
    logic [AW-1:0]         iss_rd;
    logic [AW:0]           busy_cnt;
    modport master (
        output rs, rs_used, RUWr, rd, Datawr, iss_en, iss_rd,
        input  RUrs, rs_busy, hazard, busy_cnt
    );
    modport slave (
        input  rs, rs_used, RUWr, rd, Datawr, iss_en, iss_rd,
        output RUrs, rs_busy, hazard, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with write bypass and RAW busy scoreboard
module regfile_scoreboard #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    parameter int  NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input logic                 CLK,
    input logic                 RST_N,
    regfile_scoreboard_if.slave rf
);
    logic [XLEN-1:0]       ru [NREGS];
    logic [NREGS-1:0]      busy, busy_nxt;
    logic [AW:0]           cnt, cnt_nxt;
    logic                  wb;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;

    // writeback is ignored entirely while in reset, which also disables bypass
    assign wb = RST_N & rf.RUWr & (rf.rd != '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int r = 0; r < NREGS; r++) ru[r] <= '0;
        end else if (wb) begin
            ru[rf.rd] <= rf.Datawr;
        end
    end

    // issue wins over writeback: a new producer for r is now in flight
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_nxt[r] = (rf.iss_en && rf.iss_rd == AW'(r)) ||
                          (busy[r] && !(rf.RUWr && rf.rd == AW'(r)));
            cnt_nxt += (AW+1)'(busy_nxt[r]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] idx;
        logic          hit;
        assign idx = rf.rs[g*AW +: AW];
        assign hit = wb && rf.rd == idx;
        assign rdata[g*XLEN +: XLEN] = idx == '0 ? '0 : hit ? rf.Datawr : ru[idx];
        assign rbusy[g] = idx != '0 && busy[idx] && !hit;
    end

    assign rf.RUrs     = rdata;
    assign rf.rs_busy  = rbusy;
    assign rf.hazard   = |(rf.rs_used & rbusy);
    assign rf.busy_cnt = cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector bench for the default build plus a 3-port 16x16 build
module tb_regfile_scoreboard;
    logic CLK = 1'b0;
    logic RST_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) rf ();
    regfile_scoreboard_if #(.XLEN(16), .NREGS(16), .NREAD(3)) rf3 ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .rf(rf)
    );
    regfile_scoreboard #(.XLEN(16), .NREGS(16), .NREAD(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .rf(rf3)
    );

    typedef struct {
        logic        rst_n;
        logic [4:0]  rs0, rs1;
        logic [1:0]  used;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        iss;
        logic [4:0]  ird;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic        eh;
        logic [5:0]  ec;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // rst_n rs0 rs1 used wr rd data iss ird | e0 e1 eb eh ec
        v[0]  = '{1'b0, 5'd5, 5'd31, 2'b00, 1'b1, 5'd5, 32'h0000AAAA, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0};
        v[1]  = '{1'b1, 5'd5, 5'd5,  2'b00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0};
        v[2]  = '{1'b1, 5'd5, 5'd4,  2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 6'd0};
        v[3]  = '{1'b1, 5'd5, 5'd0,  2'b00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 6'd0};
        v[4]  = '{1'b1, 5'd0, 5'd5,  2'b00, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 6'd0};
        v[5]  = '{1'b1, 5'd0, 5'd5,  2'b00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 6'd0};
        v[6]  = '{1'b1, 5'd7, 5'd7,  2'b11, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0};
        v[7]  = '{1'b1, 5'd0, 5'd7,  2'b10, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 32'h0, 2'b10, 1'b1, 6'd1};
        v[8]  = '{1'b1, 5'd7, 5'd7,  2'b10, 1'b1, 5'd7, 32'h00000055, 1'b0, 5'd0, 32'h55, 32'h55, 2'b00, 1'b0, 6'd1};
        v[9]  = '{1'b1, 5'd7, 5'd7,  2'b11, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h55, 32'h55, 2'b00, 1'b0, 6'd0};
        v[10] = '{1'b1, 5'd3, 5'd3,  2'b00, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0};
        v[11] = '{1'b1, 5'd3, 5'd7,  2'b01, 1'b1, 5'd3, 32'hCAFE0003, 1'b1, 5'd3, 32'hCAFE0003, 32'h55, 2'b00, 1'b0, 6'd1};
        v[12] = '{1'b1, 5'd3, 5'd3,  2'b01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hCAFE0003, 32'hCAFE0003, 2'b11, 1'b1, 6'd1};
        v[13] = '{1'b1, 5'd0, 5'd3,  2'b11, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h0, 32'hCAFE0003, 2'b10, 1'b1, 6'd1};
        v[14] = '{1'b1, 5'd0, 5'd3,  2'b11, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 32'hCAFE0003, 2'b10, 1'b1, 6'd1};
        v[15] = '{1'b1, 5'd3, 5'd3,  2'b00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hCAFE0003, 32'hCAFE0003, 2'b11, 1'b0, 6'd1};

        RST_N = 1'b0;
        rf.rs = '0; rf.rs_used = '0; rf.RUWr = 1'b0; rf.rd = '0; rf.Datawr = '0;
        rf.iss_en = 1'b0; rf.iss_rd = '0;
        rf3.rs = '0; rf3.rs_used = '0; rf3.RUWr = 1'b0; rf3.rd = '0; rf3.Datawr = '0;
        rf3.iss_en = 1'b0; rf3.iss_rd = '0;
        tick();

        for (int i = 0; i < 16; i++) begin
            RST_N = v[i].rst_n;
            rf.rs = {v[i].rs1, v[i].rs0};
            rf.rs_used = v[i].used;
            rf.RUWr = v[i].wr;
            rf.rd = v[i].rd;
            rf.Datawr = v[i].data;
            rf.iss_en = v[i].iss;
            rf.iss_rd = v[i].ird;
            #3;
            chk($sformatf("v%0d_rurs0", i), 64'(rf.RUrs[31:0]), 64'(v[i].e0));
            chk($sformatf("v%0d_rurs1", i), 64'(rf.RUrs[63:32]), 64'(v[i].e1));
            chk($sformatf("v%0d_rs_busy", i), 64'(rf.rs_busy), 64'(v[i].eb));
            chk($sformatf("v%0d_hazard", i), 64'(rf.hazard), 64'(v[i].eh));
            chk($sformatf("v%0d_busy_cnt", i), 64'(rf.busy_cnt), 64'(v[i].ec));
            tick();
        end
        rf.RUWr = 1'b0; rf.iss_en = 1'b0; rf.rs_used = '0;

        // 3-port build: bypass and stored reads on distinct and identical indices
        rf3.RUWr = 1'b1; rf3.rd = 4'd2; rf3.Datawr = 16'h1111; rf3.rs = {4'd0, 4'd2, 4'd15};
        #3; chk("p3_w2", 64'(rf3.RUrs), 64'({16'h0000, 16'h1111, 16'h0000}));
        tick();
        rf3.rd = 4'd4; rf3.Datawr = 16'hBEEF; rf3.rs = {4'd4, 4'd2, 4'd4};
        #3; chk("p3_w4", 64'(rf3.RUrs), 64'({16'hBEEF, 16'h1111, 16'hBEEF}));
        tick();
        rf3.rd = 4'd15; rf3.Datawr = 16'hF00D; rf3.rs = {4'd15, 4'd15, 4'd4};
        #3; chk("p3_w15", 64'(rf3.RUrs), 64'({16'hF00D, 16'hF00D, 16'hBEEF}));
        tick();
        rf3.RUWr = 1'b0; rf3.rs = {4'd2, 4'd15, 4'd0};
        #3; chk("p3_stored", 64'(rf3.RUrs), 64'({16'h1111, 16'hF00D, 16'h0000}));
        chk("p3_busy_cnt", 64'(rf3.busy_cnt), 64'd0);
        tick();

        // fill the scoreboard, then re-issue: count saturates at NREGS-1
        rf.iss_en = 1'b1;
        for (int r = 1; r < 32; r++) begin
            rf.iss_rd = 5'(r);
            tick();
        end
        rf.iss_rd = 5'd1;
        tick();
        rf.iss_en = 1'b0;
        #3; chk("busy_cnt_full", 64'(rf.busy_cnt), 64'd31);

        // reset with a concurrent writeback: bypass off, write dropped
        RST_N = 1'b0;
        rf.RUWr = 1'b1; rf.rd = 5'd9; rf.Datawr = 32'h0000FFFF;
        rf.rs = {5'd5, 5'd9}; rf.rs_used = 2'b11;
        #1;
        chk("rst_rurs0_nobypass", 64'(rf.RUrs[31:0]), 64'd0);
        chk("rst_rurs1_stored", 64'(rf.RUrs[63:32]), 64'h0DEADBEEF);
        chk("rst_rs_busy_stored", 64'(rf.rs_busy), 64'd3);
        chk("rst_hazard_stored", 64'(rf.hazard), 64'd1);
        tick();
        RST_N = 1'b1; rf.RUWr = 1'b0;
        #3;
        chk("post_rst_r9", 64'(rf.RUrs[31:0]), 64'd0);
        chk("post_rst_r5", 64'(rf.RUrs[63:32]), 64'd0);
        chk("post_rst_rs_busy", 64'(rf.rs_busy), 64'd0);
        chk("post_rst_hazard", 64'(rf.hazard), 64'd0);
        chk("post_rst_busy_cnt", 64'(rf.busy_cnt), 64'd0);
        rf3.rs = {4'd15, 4'd4, 4'd2};
        #1; chk("post_rst_p3", 64'(rf3.RUrs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
